// File: rtl/common.sv
// rtl/common.sv - shared overlay color constants and frame write arbiter state encoding
package common;

    localparam int COLOR_WIDTH = 4;

    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'h0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'h1;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'h2;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'h3;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'hF;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        CLEAR  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick, scanning from last+1 upward modulo N
module rr_priority_picker #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(last) + off) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - round-robin pixel write port arbiter with lock and full-frame clear
module frame_write_arbiter
    import common::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int NUM_REQ = 3,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_lock,
    input  logic [NUM_REQ-1:0][XW-1:0]          req_x,
    input  logic [NUM_REQ-1:0][YW-1:0]          req_y,
    input  logic [NUM_REQ-1:0][COLOR_WIDTH-1:0] req_color,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                clear_start,
    output logic                                busy,
    output logic                                clear_done,
    output logic                                wr_en,
    output logic [XW-1:0]                       wr_x,
    output logic [YW-1:0]                       wr_y,
    output logic [COLOR_WIDTH-1:0]              wr_color
);

    arb_state_t           state, next_state;
    logic [IW-1:0]        last_grant, owner, pick_idx, sel;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [XW-1:0]        cx;
    logic [YW-1:0]        cy;
    logic                 clear_pending, clear_last, xfer, arb_grant;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign clear_last = (cx == XW'(WIDTH - 1)) && (cy == YW'(HEIGHT - 1));
    assign arb_grant  = (state == ARB) && !clear_pending && (|pick_grant);
    assign xfer       = |(req_valid & req_ready);
    assign busy       = clear_pending || (state == CLEAR);

    always_comb begin
        next_state = state;
        req_ready  = '0;
        sel        = pick_idx;
        case (state)
            ARB: begin
                if (clear_pending) begin
                    next_state = CLEAR;
                end else begin
                    req_ready = pick_grant;
                    if ((|pick_grant) && req_lock[pick_idx]) next_state = LOCKED;
                end
            end
            LOCKED: begin
                sel              = owner;
                req_ready[owner] = req_valid[owner];
                // Dropping the lock ends ownership whether or not a final beat moves.
                if (!req_lock[owner]) next_state = ARB;
            end
            CLEAR: begin
                if (clear_last) next_state = ARB;
            end
            default: next_state = ARB;
        endcase
        if (!reset) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ARB;
            last_grant    <= IW'(NUM_REQ - 1);
            owner         <= '0;
            clear_pending <= 1'b0;
            cx            <= '0;
            cy            <= '0;
            wr_en         <= 1'b0;
            wr_x          <= '0;
            wr_y          <= '0;
            wr_color      <= COLOR_NONE;
            clear_done    <= 1'b0;
        end else begin
            state      <= next_state;
            wr_en      <= 1'b0;
            clear_done <= 1'b0;
            if (arb_grant) begin
                last_grant <= pick_idx;
                owner      <= pick_idx;
            end
            if (xfer) begin
                wr_en    <= 1'b1;
                wr_x     <= req_x[sel];
                wr_y     <= req_y[sel];
                wr_color <= req_color[sel];
            end
            if (state == CLEAR) begin
                wr_en    <= 1'b1;
                wr_x     <= cx;
                wr_y     <= cy;
                wr_color <= COLOR_NONE;
                if (clear_last) begin
                    cx            <= '0;
                    cy            <= '0;
                    clear_pending <= 1'b0;
                    clear_done    <= 1'b1;
                end else if (cx == XW'(WIDTH - 1)) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end else if (clear_start && !clear_pending) begin
                // A second request while one is pending or sweeping is dropped.
                clear_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_write_arbiter.sv
// tb/tb_frame_write_arbiter.sv - scoreboard bench for frame_write_arbiter with a cycle-level reference model
module tb_frame_write_arbiter;
    import common::*;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N-1:0]               req_valid, req_lock, req_ready;
    logic [N-1:0][2:0]          req_x, req_y;
    logic [N-1:0][3:0]          req_color;
    logic                       clear_start, busy, clear_done, wr_en;
    logic [2:0]                 wr_x, wr_y;
    logic [3:0]                 wr_color;

    frame_write_arbiter #(.WIDTH(W), .HEIGHT(H), .NUM_REQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .clear_done  (clear_done),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       en;
        logic [2:0] x;
        logic [2:0] y;
        logic [3:0] color;
        logic       done;
    } exp_t;

    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit checking = 0;
    logic [N-1:0] exp_ready;
    logic         exp_busy;

    // Reference model: 0=arbitrate, 1=locked, 2=clearing; clear position kept as a linear pixel index.
    int m_state, m_last, m_owner, m_k;
    bit m_pending;
    logic [2:0] m_x, m_y;
    logic [3:0] m_color;
    int xfer_idx;

    logic [N-1:0]      s_valid, s_lock;
    logic [N-1:0][2:0] s_x, s_y;
    logic [N-1:0][3:0] s_color;

    task automatic apply(input logic rst_i, input logic cs_i);
        exp_t e;
        logic [N-1:0] rdy;
        int g, old_state, c;
        reset       = rst_i;
        clear_start = cs_i;
        exp_busy    = m_pending || (m_state == 2);
        rdy = '0;
        g = -1;
        old_state = m_state;
        e.cyc = cyc + 1; e.en = 1'b0; e.x = m_x; e.y = m_y; e.color = m_color; e.done = 1'b0;
        if (!rst_i) begin
            m_state = 0; m_last = N - 1; m_owner = 0; m_pending = 0; m_k = 0;
            e.x = '0; e.y = '0; e.color = COLOR_NONE;
        end else begin
            case (m_state)
                0: begin
                    if (m_pending) m_state = 2;
                    else begin
                        for (int off = 1; off <= N; off++) begin
                            c = (m_last + off) % N;
                            if (g < 0 && req_valid[c]) g = c;
                        end
                        if (g >= 0) begin
                            m_last = g;
                            if (req_lock[g]) begin m_state = 1; m_owner = g; end
                        end
                    end
                end
                1: begin
                    if (req_valid[m_owner]) g = m_owner;
                    if (!req_lock[m_owner]) m_state = 0;
                end
                default: begin
                    e.en = 1'b1; e.x = 3'(m_k % W); e.y = 3'(m_k / W); e.color = COLOR_NONE;
                    if (m_k == W * H - 1) begin
                        e.done = 1'b1; m_k = 0; m_pending = 0; m_state = 0;
                    end else m_k++;
                end
            endcase
            if (cs_i && !m_pending && old_state != 2) m_pending = 1;
            if (g >= 0) begin
                rdy[g] = 1'b1;
                e.en = 1'b1; e.x = req_x[g]; e.y = req_y[g]; e.color = req_color[g];
            end
        end
        m_x = e.x; m_y = e.y; m_color = e.color;
        exp_ready = rdy;
        xfer_idx  = g;
        q.push_back(e);
    endtask

    task automatic cycle(input logic rst_i, input logic cs_i);
        @(posedge clk);
        #1;
        cyc++;
        req_valid = s_valid; req_lock = s_lock;
        req_x = s_x; req_y = s_y; req_color = s_color;
        apply(rst_i, cs_i);
    endtask

    task automatic rand_beats(input logic [N-1:0] vmask);
        for (int i = 0; i < N; i++) begin
            s_x[i] = 3'($urandom_range(0, W - 1));
            s_y[i] = 3'($urandom_range(0, H - 1));
            s_color[i] = 4'($urandom_range(1, 15));
        end
        s_valid = vmask;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                n_vec++;
                if (req_ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
                end
                n_vec++;
                if (busy !== exp_busy) begin
                    n_err++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
                end
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL scoreboard cyc=%0d no expectation queued", cyc);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                    if (wr_en !== e.en) begin
                        n_err++;
                        $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, e.en);
                    end
                    n_vec++;
                    if ({wr_x, wr_y, wr_color} !== {e.x, e.y, e.color}) begin
                        n_err++;
                        $display("FAIL wr_pixel cyc=%0d got x=%0d y=%0d c=%0h exp x=%0d y=%0d c=%0h",
                                 cyc, wr_x, wr_y, wr_color, e.x, e.y, e.color);
                    end
                    n_vec++;
                    if (clear_done !== e.done) begin
                        n_err++;
                        $display("FAIL clear_done cyc=%0d got=%b exp=%b", cyc, clear_done, e.done);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int beats, guard;
        s_valid = '0; s_lock = '0; s_x = '0; s_y = '0; s_color = '0;
        req_valid = '0; req_lock = '0; req_x = '0; req_y = '0; req_color = '0;
        reset = 1'b0; clear_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        m_x = '0; m_y = '0; m_color = COLOR_NONE;
        e_init: begin
            exp_t e0;
            e0.cyc = 0; e0.en = 1'b0; e0.x = '0; e0.y = '0; e0.color = COLOR_NONE; e0.done = 1'b0;
            q.push_back(e0);
        end
        m_state = 0; m_last = N - 1; m_owner = 0; m_pending = 0; m_k = 0;
        apply(1'b0, 1'b0);
        checking = 1;

        repeat (3) cycle(1'b1, 1'b0);

        // All three valid without lock: round-robin from requester 0.
        for (int t = 0; t < 6; t++) begin
            rand_beats(3'b111);
            s_lock = '0;
            cycle(1'b1, 1'b0);
        end

        // Locked square from requester 0 (optionally with a clear pulse during the lock).
        for (int pass = 0; pass < 2; pass++) begin
            s_valid = 3'b010; s_lock = '0;
            while (m_last != 2 && guard < 10) begin cycle(1'b1, 1'b0); guard++; end
            guard = 0;
            beats = 0;
            for (int t = 0; t < 20 && beats < 4; t++) begin
                rand_beats(3'b011);
                s_x[0] = 3'(beats % 2); s_y[0] = 3'(beats / 2); s_color[0] = COLOR_BLUE;
                s_lock = {2'b00, beats < 3};
                cycle(1'b1, (pass == 1 && t == 1));
                if (xfer_idx == 0) beats++;
            end
            n_vec++;
            if (beats != 4) begin
                n_err++;
                $display("FAIL lock_beats pass=%0d got=%0d exp=4", pass, beats);
            end
            s_lock = '0;
            rand_beats(3'b010);
            cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b0);
        end

        // Let the clear run, with a second pulse mid-sweep that must be ignored.
        guard = 0;
        while ((m_state == 2 || m_pending) && guard < 200) begin
            rand_beats(3'b111);
            cycle(1'b1, (m_k == 30));
            guard++;
        end
        n_vec++;
        if (guard >= 200) begin n_err++; $display("FAIL clear_finish got=timeout exp=idle"); end

        // Reset landing on the (3,2) clear pixel.
        s_valid = '0;
        cycle(1'b1, 1'b1);
        guard = 0;
        while (!(m_state == 2 && m_k == 19) && guard < 100) begin cycle(1'b1, 1'b0); guard++; end
        n_vec++;
        if (guard >= 100) begin n_err++; $display("FAIL reach_pixel got=timeout exp=k19"); end
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        rand_beats(3'b100);
        cycle(1'b1, 1'b0);
        s_valid = '0;
        cycle(1'b1, 1'b0);

        // Randomized traffic with occasional locks and clears.
        for (int t = 0; t < 400; t++) begin
            rand_beats(N'($urandom_range(0, 7)));
            for (int i = 0; i < N; i++) s_lock[i] = ($urandom_range(0, 2) == 0);
            cycle(1'b1, ($urandom_range(0, 59) == 0));
        end

        s_valid = '0; s_lock = '0;
        repeat (2) cycle(1'b1, 1'b0);
        @(negedge clk);
        #1;
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
- Shares the single pixel write port of the overlay frame between NUM_REQ pixel producers: cursor renderer, brush painter, shape drawer.
- Grants are round-robin, one pixel per cycle. A lock lets a producer finish a multi-pixel sequence, such as the 4-pixel cursor square, without interleaving.
- Contains a built-in clear sequencer that sweeps the whole frame to COLOR_NONE on request.
- Sits between the producers and the frame storage; its output is a registered write strobe.

Parameters:
WIDTH, 640, frame width in pixels
HEIGHT, 480, frame height in pixels
NUM_REQ, 3, number of requesters (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a pixel to write
req_lock  in  NUM_REQ  requester i holds the port after its current beat
req_x  in  NUM_REQ x $clog2(WIDTH)  pixel x per requester
req_y  in  NUM_REQ x $clog2(HEIGHT)  pixel y per requester
req_color  in  NUM_REQ x COLOR_WIDTH  pixel color per requester
req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready
clear_start  in  1  one-cycle pulse requesting a full-frame clear
busy  out  1  clear pending or in progress
clear_done  out  1  one-cycle pulse after the last clear pixel is issued
wr_en  out  1  frame write strobe
wr_x  out  $clog2(WIDTH)  write x
wr_y  out  $clog2(HEIGHT)  write y
wr_color  out  COLOR_WIDTH  write color

Behaviour:
- Reset (reset==0 at posedge):
  - State ARB; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - clear_pending=0; clear counters=0.
  - wr_en=0, wr_x=0, wr_y=0, wr_color=COLOR_NONE; clear_done=0.
  - req_ready is forced to all-0 while reset is low.
  - Reset mid-lock or mid-clear abandons that operation with no clear_done.
- A transfer on i is req_valid[i]&req_ready[i]. req_ready is combinational from state and req_valid; at most one bit is high per cycle.
- ARB state:
  - If clear_pending: no ready is given; go to CLEAR next cycle.
  - Otherwise grant the first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Assert its ready and set last_grant to it.
  - If the granted beat has req_lock[i]=1, go to LOCKED with owner=i. Otherwise stay in ARB.
- LOCKED state:
  - req_ready[owner]=req_valid[owner]; all other readies are 0.
  - A transfer with req_lock[owner]=0 is the final beat; return to ARB.
  - If req_lock[owner] drops with no valid, return to ARB; no write occurs.
  - clear_start during LOCKED only sets clear_pending; the lock always finishes first.
- CLEAR state:
  - Issue one write per cycle with wr_color=COLOR_NONE, scanning x 0..WIDTH-1 inner and y 0..HEIGHT-1 outer.
  - After (WIDTH-1,HEIGHT-1) is issued: clear_pending=0, clear_done=1 for one cycle (aligned with the last wr_en), then return to ARB.
  - A clear takes exactly WIDTH*HEIGHT write cycles. All req_ready are 0 throughout.
- clear_start:
  - Sets clear_pending on the following edge.
  - A pulse while pending or in CLEAR is ignored; no queueing of a second clear.
  - A pulse in the same cycle as an ARB grant: the grant proceeds, and the clear starts after that beat or after the resulting lock ends.
- Write port:
  - Registered with 1-cycle latency: a transfer at edge N produces wr_en=1 and that beat's x/y/color in cycle N+1.
  - wr_en=0 in idle cycles; wr_x, wr_y, wr_color hold their last values.
- busy = clear_pending | (state==CLEAR).
- Coordinates pass through unchecked; producers guarantee x<WIDTH and y<HEIGHT.

Decomposition:
- common.sv already provides COLOR_WIDTH, COLOR_NONE and the color constants.
- Add the arbiter state enum (ARB, LOCKED, CLEAR) to common.sv.
- One sub-module, rr_priority_picker #(N): inputs req[N-1:0] and last[$clog2(N)-1:0]; outputs one-hot grant and an index. Purely combinational and reusable.

Test Plan (WIDTH=8, HEIGHT=8, NUM_REQ=3):
- Reset hold then release with no requests -> wr_en=0, req_ready=000, busy=0, wr_color=COLOR_NONE.
- All three valid, lock=0, for 6 cycles -> grant order 0,1,2,0,1,2; each wr_* matches the granted beat one cycle later.
- Requester 0 locked for 4 beats (0,0),(1,0),(0,1),(1,1), BLUE, with req 1 valid throughout -> four consecutive writes from req 0, then req 1 is granted.
- clear_start pulsed during the lock -> busy=1 at once; after the lock, 64 writes of COLOR_NONE from (0,0) to (7,7); clear_done is high with the (7,7) write; req_ready=000 throughout.
- Second clear_start mid-clear -> still exactly 64 writes and one clear_done.
- reset asserted mid-clear at pixel (3,2) -> next cycle wr_en=0, busy=0, no clear_done; after release, requester 2 is served normally.
